sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//   Shares the external 32-bit SRAM (two 256Kx16 chips, chip 1 on data[31:16], chip 0 on [15:0])
//   between two 68k-style 16-bit requesters: port 0 = boot loader, port 1 = CPU bus.
//   Sequences each access as SETUP/ACCESS/HOLD strobes on ram_* pins; returns a one-cycle ack.
//   Sits inside top, between mem/boot logic and the ram_* top-level pins.
// PARAMETERS
//   WAIT_CYCLES  2   cycles oe_n/we_n held active in ACCESS (legal range 1..15)
// PORTS
//   clk                 in   1   system clock; all logic on rising edge
//   reset_n             in   1   asynchronous, active-low reset
//   pN_req (N=0,1)      in   1   access request, level; held until pN_ack
//   pN_addr             in   19  word address; bit0=0 -> chip 1 (upper lanes), bit0=1 -> chip 0
//   pN_rw               in   1   1 = read, 0 = write (68k polarity)
//   pN_uds / pN_lds     in   1   upper / lower byte lane enable
//   pN_wdata            in   16  write data
//   pN_rdata            out  16  read data, valid in the pN_ack cycle, holds until next pN read
//   pN_ack              out  1   one-cycle completion pulse
//   ram_addr            out  18  pN_addr[18:1]
//   ram_data_write      out  32  wdata replicated on both halves
//   ram_data_read       in   32  from SRAM pins
//   ram_data_is_output  out  1   tristate enable for write data
//   ram_ce_n/ub_n/lb_n/we_n/oe_n  out  2 each  per-chip strobes, index = chip number
// BEHAVIOUR
//   - Reset (async): FSM=IDLE; all ram_*_n = 2'b11; ram_data_is_output=0; ram_addr=0;
//     ram_data_write=0; pN_ack=0; pN_rdata=0. Reset mid-access aborts at once, no ack issued.
//   - FSM: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> HOLD -> IDLE. All outputs registered.
//   - IDLE: samples req; on any req grants a port, latches addr/rw/uds/lds/wdata. Only IDLE samples.
//   - SETUP (1 cycle): ram_addr, selected ce_n, ub_n=~uds, lb_n=~lds asserted; read: oe_n low;
//     write: ram_data_is_output=1, we_n still high.
//   - ACCESS: read keeps oe_n low; write drives we_n low. Unselected chip: all strobes high.
//   - Read capture: selected chip's 16 lanes of ram_data_read latched at last ACCESS edge.
//   - HOLD (1 cycle): we_n/oe_n high, ce_n/lanes/data still driven (hold time); granted pN_ack=1.
//   - Latency: req sampled at edge E -> ack high during the cycle following edge E+WAIT_CYCLES+2
//     (WAIT_CYCLES=2: 4 edges). Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
//   - Handshake: requester drops req at the edge where it sees ack, unless issuing a new access
//     (req kept high after ack = new request, sampled in the following IDLE cycle).
//   - req dropped mid-access: access completes, ack still pulsed. req changes after grant ignored.
//   - uds=lds=0: full cycle runs with both lane strobes high; ack issued; rdata unchanged.
//   - Simultaneous req: resolved by arbitration policy (CONFIGURATION).
// CONFIGURATION
//   SRAM_ARB_RR_EN undefined: fixed priority, port 0 wins every tie (boot loader first).
//   SRAM_ARB_RR_EN defined: round-robin; 1-bit last_grant register, tie goes to port != last_grant;
//     last_grant resets to 1 so port 0 wins the first tie; a lone request is granted in either mode.
// STRUCTURE
//   Package sram_arb_pkg: FSM state encoding (IDLE, SETUP, ACCESS, HOLD), CHIP_HI=1/CHIP_LO=0,
//     wait-counter width constant.
//   Sub-module sram_arb_pick: combinational grant from req[1:0] + last_grant (RR logic under macro).
//   Top level holds FSM, wait counter, latched request, pin registers, rdata/ack registers.
// TESTING
//   1 write p1 addr=19'h00000 uds=lds=1 wdata=16'hCAFE -> chip1 ce_n=2'b01, we_n low 2 cycles,
//     data[31:16]=CAFE; p1_ack 4 edges after req sampled.
//   2 read p1 addr=19'h00001, SRAM model returns 16'h1234 on [15:0] -> chip0 oe_n low,
//     p1_rdata=16'h1234 in ack cycle.
//   3 write p0 addr=19'h00002 uds=1 lds=0 wdata=16'hAB00 -> ub_n[1]=0, lb_n[1]=1; read back
//     upper byte AB, lower byte unchanged.
//   4 p0 and p1 req same edge, held, 4 accesses -> fixed: p0,p0,p0,p0 (p1 starved);
//     with SRAM_ARB_RR_EN: p0,p1,p0,p1.
//   5 reset_n low during ACCESS of a write -> same-cycle we_n/ce_n=2'b11, no ack; after release
//     a fresh p1 read completes normally.
//   6 WAIT_CYCLES=5 -> we_n low exactly 5 cycles; ack 7 edges after req sampled.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// FSM encoding, chip indices and wait-counter sizing live here.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic CHIP_HI = 1'b1;
  localparam logic CHIP_LO = 1'b0;

  // Wide enough for the largest legal WAIT_CYCLES (15).
  localparam int CNT_W = 4;

  // Even word addresses live in chip 1 (upper lanes), odd ones in chip 0.
  function automatic logic chip_of(input logic addr0);
    return addr0 ? CHIP_LO : CHIP_HI;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection between the two requesters.
// Round-robin tie-break when SRAM_ARB_RR_EN is defined, else fixed priority to port 0.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       port_o
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    valid_o = |req_i;
    port_o  = req_i[1];
    if (req_i == 2'b11) begin
      port_o = ~last_grant_i;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    valid_o = |req_i;
    port_o  = ~req_i[0];
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter sequencing SETUP/ACCESS/HOLD cycles on a 2x16-bit external SRAM.
// Optional round-robin arbitration: define SRAM_ARB_RR_EN (default is fixed priority, port 0 first).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        p0_req,
  input  logic [18:0] p0_addr,
  input  logic        p0_rw,
  input  logic        p0_uds,
  input  logic        p0_lds,
  input  logic [15:0] p0_wdata,
  output logic [15:0] p0_rdata,
  output logic        p0_ack,

  input  logic        p1_req,
  input  logic [18:0] p1_addr,
  input  logic        p1_rw,
  input  logic        p1_uds,
  input  logic        p1_lds,
  input  logic [15:0] p1_wdata,
  output logic [15:0] p1_rdata,
  output logic        p1_ack,

  output logic [17:0] ram_addr,
  output logic [31:0] ram_data_write,
  input  logic [31:0] ram_data_read,
  output logic        ram_data_is_output,
  output logic [1:0]  ram_ce_n,
  output logic [1:0]  ram_ub_n,
  output logic [1:0]  ram_lb_n,
  output logic [1:0]  ram_we_n,
  output logic [1:0]  ram_oe_n
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             load;

  logic             pick_valid;
  logic             pick_port;

  logic             port_q;
  logic [18:0]      addr_q;
  logic             rw_q;
  logic             uds_q;
  logic             lds_q;
  logic [15:0]      wdata_q;

  logic [17:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_wdata_q, ram_wdata_d;
  logic             dout_en_q, dout_en_d;
  logic [1:0]       ce_n_q, ce_n_d;
  logic [1:0]       ub_n_q, ub_n_d;
  logic [1:0]       lb_n_q, lb_n_d;
  logic [1:0]       we_n_q, we_n_d;
  logic [1:0]       oe_n_q, oe_n_d;

  logic [15:0]      p0_rdata_q, p1_rdata_q;
  logic             p0_ack_q, p1_ack_q;
  logic             chip;
  logic [15:0]      rd_lane;
  logic             capture;

  sram_arb_pick u_pick (
    .req_i        ({p1_req, p0_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .port_o       (pick_port)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    load         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          load         = 1'b1;
          last_grant_d = pick_port;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = WAIT_LAST;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch: only written when IDLE grants, so later req/addr changes are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      port_q  <= pick_port;
      addr_q  <= pick_port ? p1_addr  : p0_addr;
      rw_q    <= pick_port ? p1_rw    : p0_rw;
      uds_q   <= pick_port ? p1_uds   : p0_uds;
      lds_q   <= pick_port ? p1_lds   : p0_lds;
      wdata_q <= pick_port ? p1_wdata : p0_wdata;
    end
  end

  assign chip = chip_of(addr_q[0]);

  // Pin registers load from the current state, so the pins trail the FSM by one cycle.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    dout_en_d   = 1'b0;
    ce_n_d      = 2'b11;
    ub_n_d      = 2'b11;
    lb_n_d      = 2'b11;
    we_n_d      = 2'b11;
    oe_n_d      = 2'b11;
    if (state_q != ST_IDLE) begin
      ram_addr_d   = addr_q[18:1];
      ce_n_d[chip] = 1'b0;
      ub_n_d[chip] = ~uds_q;
      lb_n_d[chip] = ~lds_q;
      if (!rw_q) begin
        dout_en_d   = 1'b1;
        ram_wdata_d = {wdata_q, wdata_q};
        if (state_q == ST_ACCESS) begin
          we_n_d[chip] = 1'b0;
        end
      end else if (state_q != ST_HOLD) begin
        oe_n_d[chip] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      dout_en_q   <= 1'b0;
      ce_n_q      <= 2'b11;
      ub_n_q      <= 2'b11;
      lb_n_q      <= 2'b11;
      we_n_q      <= 2'b11;
      oe_n_q      <= 2'b11;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      dout_en_q   <= dout_en_d;
      ce_n_q      <= ce_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  // The HOLD-state edge closes the last ACCESS pin cycle: sample read data and raise ack.
  assign rd_lane = (chip == CHIP_HI) ? ram_data_read[31:16] : ram_data_read[15:0];
  assign capture = (state_q == ST_HOLD) && rw_q && (uds_q || lds_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      p0_ack_q <= (state_q == ST_HOLD) && !port_q;
      p1_ack_q <= (state_q == ST_HOLD) &&  port_q;
      if (capture && !port_q) begin
        p0_rdata_q <= rd_lane;
      end
      if (capture && port_q) begin
        p1_rdata_q <= rd_lane;
      end
    end
  end

  assign p0_ack             = p0_ack_q;
  assign p1_ack             = p1_ack_q;
  assign p0_rdata           = p0_rdata_q;
  assign p1_rdata           = p1_rdata_q;
  assign ram_addr           = ram_addr_q;
  assign ram_data_write     = ram_wdata_q;
  assign ram_data_is_output = dout_en_q;
  assign ram_ce_n           = ce_n_q;
  assign ram_ub_n           = ub_n_q;
  assign ram_lb_n           = lb_n_q;
  assign ram_we_n           = we_n_q;
  assign ram_oe_n           = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: WAIT_CYCLES=2 instance with an SRAM model,
// plus a WAIT_CYCLES=5 instance for strobe-length and latency checks.
module tb_sram_arbiter;

  logic        clk;
  logic        reset_n;

  logic        p0_req, p0_rw, p0_uds, p0_lds;
  logic [18:0] p0_addr;
  logic [15:0] p0_wdata, p0_rdata;
  logic        p0_ack;
  logic        p1_req, p1_rw, p1_uds, p1_lds;
  logic [18:0] p1_addr;
  logic [15:0] p1_wdata, p1_rdata;
  logic        p1_ack;
  logic [17:0] ram_addr;
  logic [31:0] ram_dw, ram_dr;
  logic        ram_dio;
  logic [1:0]  ce_n, ub_n, lb_n, we_n, oe_n;

  logic        b_req, b_rw;
  logic [18:0] b_addr;
  logic [15:0] b_wdata, b_rdata0, b_rdata1;
  logic        b_ack0, b_ack1;
  logic [17:0] b_ram_addr;
  logic [31:0] b_dw;
  logic        b_dio;
  logic [1:0]  b_ce_n, b_ub_n, b_lb_n, b_we_n, b_oe_n;

  logic [15:0] mem_hi [0:15];
  logic [15:0] mem_lo [0:15];

  typedef struct {
    bit          port;
    int          lat;
    logic [15:0] rdata;
    bit          chk_rd;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_rw(p0_rw), .p0_uds(p0_uds), .p0_lds(p0_lds),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_rw(p1_rw), .p1_uds(p1_uds), .p1_lds(p1_lds),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .ram_addr(ram_addr), .ram_data_write(ram_dw), .ram_data_read(ram_dr),
    .ram_data_is_output(ram_dio), .ram_ce_n(ce_n), .ram_ub_n(ub_n), .ram_lb_n(lb_n),
    .ram_we_n(we_n), .ram_oe_n(oe_n)
  );

  sram_arbiter #(.WAIT_CYCLES(5)) dut_w5 (
    .clk(clk), .reset_n(reset_n),
    .p0_req(b_req), .p0_addr(b_addr), .p0_rw(b_rw), .p0_uds(1'b1), .p0_lds(1'b1),
    .p0_wdata(b_wdata), .p0_rdata(b_rdata0), .p0_ack(b_ack0),
    .p1_req(1'b0), .p1_addr(19'h0), .p1_rw(1'b1), .p1_uds(1'b0), .p1_lds(1'b0),
    .p1_wdata(16'h0), .p1_rdata(b_rdata1), .p1_ack(b_ack1),
    .ram_addr(b_ram_addr), .ram_data_write(b_dw), .ram_data_read(32'h0),
    .ram_data_is_output(b_dio), .ram_ce_n(b_ce_n), .ram_ub_n(b_ub_n), .ram_lb_n(b_lb_n),
    .ram_we_n(b_we_n), .ram_oe_n(b_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-lane writes while ce_n and we_n are both low; reset restores the preload.
  assign ram_dr = {mem_hi[ram_addr[3:0]], mem_lo[ram_addr[3:0]]};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_hi[i] <= 16'h0;
        mem_lo[i] <= 16'h0;
      end
      mem_lo[0] <= 16'h1234;
      mem_hi[1] <= 16'h5566;
    end else begin
      if (!ce_n[1] && !we_n[1]) begin
        if (!ub_n[1]) mem_hi[ram_addr[3:0]][15:8] <= ram_dw[31:24];
        if (!lb_n[1]) mem_hi[ram_addr[3:0]][7:0]  <= ram_dw[23:16];
      end
      if (!ce_n[0] && !we_n[0]) begin
        if (!ub_n[0]) mem_lo[ram_addr[3:0]][15:8] <= ram_dw[15:8];
        if (!lb_n[0]) mem_lo[ram_addr[3:0]][7:0]  <= ram_dw[7:0];
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Drives one access on the main DUT and records what the pins and ack did; called #1 after a posedge.
  task automatic run_access(input bit port, input logic [18:0] addr, input bit rw,
                            input bit uds, input bit lds, input logic [15:0] wd,
                            output int lat, output int we_cnt, output int oe_cnt,
                            output logic [1:0] ce_s, output logic [1:0] ub_s,
                            output logic [1:0] lb_s, output logic [31:0] dw_s,
                            output bit ack_port, output logic [15:0] rd, output bit to);
    lat = -1; we_cnt = 0; oe_cnt = 0; ce_s = 2'b11; ub_s = 2'b11; lb_s = 2'b11;
    dw_s = '0; ack_port = 1'b0; rd = '0; to = 1'b1;
    if (port) begin
      p1_addr = addr; p1_rw = rw; p1_uds = uds; p1_lds = lds; p1_wdata = wd; p1_req = 1'b1;
    end else begin
      p0_addr = addr; p0_rw = rw; p0_uds = uds; p0_lds = lds; p0_wdata = wd; p0_req = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ce_n != 2'b11) begin ce_s = ce_n; ub_s = ub_n; lb_s = lb_n; end
      if (we_n != 2'b11) begin we_cnt++; dw_s = ram_dw; end
      if (oe_n != 2'b11) oe_cnt++;
      if (p0_ack || p1_ack) begin
        lat = k - 1;
        ack_port = p1_ack;
        rd = p1_ack ? p1_rdata : p0_rdata;
        to = 1'b0;
        break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({ce_n, ub_n, lb_n, we_n, oe_n} !== 10'h3FF || ram_dio !== 1'b0 || ram_addr !== 18'h0 ||
        ram_dw !== 32'h0 || p0_ack !== 1'b0 || p1_ack !== 1'b0 || p0_rdata !== 16'h0 ||
        p1_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: strobes=%h dio=%b addr=%h dw=%h ack=%b%b rd=%h/%h required strobes=3ff rest 0",
               {ce_n, ub_n, lb_n, we_n, oe_n}, ram_dio, ram_addr, ram_dw, p1_ack, p0_ack, p0_rdata, p1_rdata);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_write_p1();
    int lat, wc, oc; logic [1:0] ce_s, ub_s, lb_s; logic [31:0] dw; bit ap, to; logic [15:0] rd;
    exp_t e;
    sb.push_back('{1'b1, 4, 16'h0, 1'b0});
    run_access(1'b1, 19'h00000, 1'b0, 1'b1, 1'b1, 16'hCAFE, lat, wc, oc, ce_s, ub_s, lb_s, dw, ap, rd, to);
    e = sb.pop_front();
    n_tests++;
    if (to || ap !== e.port || lat != e.lat) begin
      n_fail++; $display("FAIL write_p1_ack: timeout=%0d port=%0d lat=%0d required port=%0d lat=%0d", to, ap, lat, e.port, e.lat);
    end
    n_tests++;
    if (wc != 2 || ce_s !== 2'b01 || oc != 0) begin
      n_fail++; $display("FAIL write_p1_strobes: we_cycles=%0d ce_n=%b oe_cycles=%0d required 2 01 0", wc, ce_s, oc);
    end
    n_tests++;
    if (dw[31:16] !== 16'hCAFE || mem_hi[0] !== 16'hCAFE) begin
      n_fail++; $display("FAIL write_p1_data: pins=%h mem=%h required cafe", dw[31:16], mem_hi[0]);
    end
  endtask

  task automatic test_read_p1();
    int lat, wc, oc; logic [1:0] ce_s, ub_s, lb_s; logic [31:0] dw; bit ap, to; logic [15:0] rd;
    exp_t e;
    sb.push_back('{1'b1, 4, 16'h1234, 1'b1});
    run_access(1'b1, 19'h00001, 1'b1, 1'b1, 1'b1, 16'h0, lat, wc, oc, ce_s, ub_s, lb_s, dw, ap, rd, to);
    e = sb.pop_front();
    n_tests++;
    if (to || ap !== e.port || lat != e.lat || rd !== e.rdata) begin
      n_fail++; $display("FAIL read_p1: timeout=%0d port=%0d lat=%0d rdata=%h required %0d %0d %h", to, ap, lat, rd, e.port, e.lat, e.rdata);
    end
    n_tests++;
    if (oc != 3 || wc != 0 || ce_s !== 2'b10) begin
      n_fail++; $display("FAIL read_p1_strobes: oe_cycles=%0d we_cycles=%0d ce_n=%b required 3 0 10", oc, wc, ce_s);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (p1_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL read_p1_hold: rdata=%h required 1234", p1_rdata);
    end
  endtask

  task automatic test_byte_lanes();
    int lat, wc, oc; logic [1:0] ce_s, ub_s, lb_s; logic [31:0] dw; bit ap, to; logic [15:0] rd;
    exp_t e;
    sb.push_back('{1'b0, 4, 16'h0, 1'b0});
    run_access(1'b0, 19'h00002, 1'b0, 1'b1, 1'b0, 16'hAB00, lat, wc, oc, ce_s, ub_s, lb_s, dw, ap, rd, to);
    e = sb.pop_front();
    n_tests++;
    if (to || ap !== e.port || ub_s !== 2'b01 || lb_s !== 2'b11 || mem_hi[1] !== 16'hAB66) begin
      n_fail++; $display("FAIL byte_write: timeout=%0d port=%0d ub_n=%b lb_n=%b mem=%h required 0 01 11 ab66", to, ap, ub_s, lb_s, mem_hi[1]);
    end
    sb.push_back('{1'b0, 4, 16'hAB66, 1'b1});
    run_access(1'b0, 19'h00002, 1'b1, 1'b1, 1'b1, 16'h0, lat, wc, oc, ce_s, ub_s, lb_s, dw, ap, rd, to);
    e = sb.pop_front();
    n_tests++;
    if (to || ap !== e.port || rd !== e.rdata) begin
      n_fail++; $display("FAIL byte_readback: timeout=%0d port=%0d rdata=%h required 0 %h", to, ap, rd, e.rdata);
    end
    // No lanes enabled: cycle still runs and acks, but rdata must keep the previous value.
    sb.push_back('{1'b0, 4, 16'hAB66, 1'b1});
    run_access(1'b0, 19'h00001, 1'b1, 1'b0, 1'b0, 16'h0, lat, wc, oc, ce_s, ub_s, lb_s, dw, ap, rd, to);
    e = sb.pop_front();
    n_tests++;
    if (to || ap !== e.port || lat != e.lat || rd !== e.rdata || ub_s !== 2'b11 || lb_s !== 2'b11) begin
      n_fail++; $display("FAIL no_lane_read: timeout=%0d lat=%0d rdata=%h ub_n=%b lb_n=%b required 4 %h 11 11", to, lat, rd, ub_s, lb_s, e.rdata);
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    int acks = 0, last_k = 0, extra = 0;
    apply_reset();
`ifdef SRAM_ARB_RR_EN
    sb.push_back('{1'b0, 0, 16'h1234, 1'b1}); sb.push_back('{1'b1, 5, 16'h0000, 1'b1});
    sb.push_back('{1'b0, 5, 16'h1234, 1'b1}); sb.push_back('{1'b1, 5, 16'h0000, 1'b1});
`else
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, (i == 0) ? 0 : 5, 16'h1234, 1'b1});
`endif
    p0_addr = 19'h00001; p0_rw = 1'b1; p0_uds = 1'b1; p0_lds = 1'b1; p0_wdata = 16'h0;
    p1_addr = 19'h00000; p1_rw = 1'b1; p1_uds = 1'b1; p1_lds = 1'b1; p1_wdata = 16'h0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 1; k <= 60 && acks < 4; k++) begin
      @(posedge clk);
      #1;
      if (p0_ack || p1_ack) begin
        e = sb.pop_front();
        n_tests++;
        if (p1_ack !== e.port || (acks > 0 && k - last_k != e.lat) ||
            (p1_ack ? p1_rdata : p0_rdata) !== e.rdata) begin
          n_fail++; $display("FAIL arb_order[%0d]: port=%0d gap=%0d rdata=%h required port=%0d gap=%0d rdata=%h",
                             acks, p1_ack, k - last_k, p1_ack ? p1_rdata : p0_rdata, e.port, e.lat, e.rdata);
        end
        acks++;
        last_k = k;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    n_tests++;
    if (acks != 4) begin
      n_fail++; $display("FAIL arb_count: acks=%0d required 4", acks);
      sb.delete();
    end
    repeat (8) begin
      @(posedge clk);
      #1;
      if (p0_ack || p1_ack) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL arb_idle_after_drop: extra acks=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, wc, oc; logic [1:0] ce_s, ub_s, lb_s; logic [31:0] dw; bit ap, to; logic [15:0] rd;
    exp_t e;
    int seen = 0, acks = 0;
    p1_addr = 19'h00004; p1_rw = 1'b0; p1_uds = 1'b1; p1_lds = 1'b1; p1_wdata = 16'hBEEF; p1_req = 1'b1;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (we_n != 2'b11) seen = 1;
    end
    n_tests++;
    if (seen == 0) begin
      n_fail++; $display("FAIL reset_mid_we_seen: we_n never went low, required low");
    end
    #2 reset_n = 1'b0;
    p1_req = 1'b0;
    #1;
    n_tests++;
    if (we_n !== 2'b11 || ce_n !== 2'b11 || ram_dio !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_pins: we_n=%b ce_n=%b dio=%b required 11 11 0", we_n, ce_n, ram_dio);
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (p0_ack || p1_ack) acks++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (p0_ack || p1_ack) acks++;
    end
    n_tests++;
    if (acks != 0) begin
      n_fail++; $display("FAIL reset_mid_no_ack: acks=%0d required 0", acks);
    end
    sb.push_back('{1'b1, 4, 16'h1234, 1'b1});
    run_access(1'b1, 19'h00001, 1'b1, 1'b1, 1'b1, 16'h0, lat, wc, oc, ce_s, ub_s, lb_s, dw, ap, rd, to);
    e = sb.pop_front();
    n_tests++;
    if (to || ap !== e.port || lat != e.lat || rd !== e.rdata) begin
      n_fail++; $display("FAIL reset_mid_fresh_read: timeout=%0d port=%0d lat=%0d rdata=%h required %0d %0d %h", to, ap, lat, rd, e.port, e.lat, e.rdata);
    end
  endtask

  task automatic test_wait5();
    exp_t e;
    int lat = -1, wc = 0;
    sb.push_back('{1'b0, 7, 16'h0, 1'b0});
    b_addr = 19'h00000; b_rw = 1'b0; b_wdata = 16'h1111; b_req = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (b_we_n != 2'b11) wc++;
      if (b_ack0 || b_ack1) begin
        lat = k - 1;
        b_req = 1'b0;
      end
    end
    b_req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (lat != e.lat || b_ack1 !== 1'b0) begin
      n_fail++; $display("FAIL wait5_latency: lat=%0d required %0d", lat, e.lat);
    end
    n_tests++;
    if (wc != 5) begin
      n_fail++; $display("FAIL wait5_we_width: we_cycles=%0d required 5", wc);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p0_rw = 1'b1; p0_uds = 1'b0; p0_lds = 1'b0; p0_wdata = '0;
    p1_req = 1'b0; p1_addr = '0; p1_rw = 1'b1; p1_uds = 1'b0; p1_lds = 1'b0; p1_wdata = '0;
    b_req = 1'b0; b_addr = '0; b_rw = 1'b1; b_wdata = '0;
    test_reset();
    test_write_p1();
    test_read_p1();
    test_byte_lanes();
    test_arbitration();
    test_reset_mid_access();
    test_wait5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
